// File: rtl/trdb_packet_scheduler.sv
// trdb_packet_scheduler: per-hart packet decode into one-entry slots, round-robin valid/ready output.
// Define TRDB_RESYNC_EN to build the per-hart periodic resync counters.
package trdb_pkg;
  typedef enum logic [1:0] {
    F_BRANCH_FULL = 2'b00,
    F_BRANCH_DIFF = 2'b01,
    F_ADDR_ONLY   = 2'b10,
    F_SYNC        = 2'b11
  } trdb_format_t;
  typedef enum logic [1:0] {
    SF_START     = 2'b00,
    SF_EXCEPTION = 2'b01,
    SF_CONTEXT   = 2'b10,
    SF_UNDEF     = 2'b11
  } trdb_subformat_t;
endpackage

module trdb_packet_scheduler
  import trdb_pkg::*;
#(
  parameter int NHARTS = 2,
  parameter int RESYNC_MAX = 64,
  localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NHARTS-1:0] valid_i,
  input  logic [NHARTS-1:0] lc_exception_i,
  input  logic [NHARTS-1:0] lc_exception_sync_i,
  input  logic [NHARTS-1:0] tc_first_qualified_i,
  input  logic [NHARTS-1:0] tc_unhalted_i,
  input  logic [NHARTS-1:0] tc_privchange_i,
  input  logic [NHARTS-1:0] lc_u_discontinuity_i,
  input  logic [NHARTS-1:0] nc_halt_i,
  input  logic [NHARTS-1:0] nc_exception_i,
  input  logic [NHARTS-1:0] nc_privchange_i,
  input  logic [NHARTS-1:0] nc_unqualified_i,
  input  logic [NHARTS-1:0] branch_map_full_i,
  input  logic [NHARTS-1:0] tc_context_change_i,
  input  logic [NHARTS-1:0] branch_map_empty_i,
  output logic [NHARTS-1:0] stall_o,
  output logic              valid_o,
  input  logic              ready_i,
  output trdb_format_t      packet_format_o,
  output trdb_subformat_t   packet_subformat_o,
  output logic [HW-1:0]     hart_id_o,
  output logic              resync_o
);
  if (NHARTS < 1 || RESYNC_MAX < 1) begin : g_bad_param
    $error("trdb_packet_scheduler: NHARTS and RESYNC_MAX must be >= 1");
  end

  logic [NHARTS-1:0] r_full, r_rs, r_exc;
  trdb_format_t      r_fmt [NHARTS];
  trdb_subformat_t   r_sub [NHARTS];
  logic [HW-1:0]     r_rr, r_lock_id;
  logic              r_lock;
  logic [NHARTS-1:0] w_req, w_rs, w_pend, w_take;
  trdb_format_t      w_fmt [NHARTS];
  trdb_subformat_t   w_sub [NHARTS];
  logic [HW-1:0]     w_grant;
  logic              w_valid, w_hs;

  always_comb begin
    for (int h = 0; h < NHARTS; h++) begin
      w_req[h] = valid_i[h];
      w_rs[h] = 1'b0;
      w_fmt[h] = F_SYNC;
      w_sub[h] = SF_START;
      if (lc_exception_i[h]) w_sub[h] = SF_EXCEPTION;
      else if ((lc_exception_sync_i[h] & ~r_exc[h]) | tc_first_qualified_i[h] | tc_unhalted_i[h] | tc_privchange_i[h]) w_sub[h] = SF_START;
      else if (lc_u_discontinuity_i[h]) begin
        w_fmt[h] = branch_map_empty_i[h] ? F_ADDR_ONLY : F_BRANCH_FULL;
        w_sub[h] = SF_UNDEF;
      end
      else if (w_pend[h]) w_rs[h] = 1'b1;
      else if (nc_halt_i[h] | nc_exception_i[h] | nc_privchange_i[h] | nc_unqualified_i[h]) begin
        w_fmt[h] = branch_map_empty_i[h] ? F_ADDR_ONLY : F_BRANCH_FULL;
        w_sub[h] = SF_UNDEF;
      end
      else if (branch_map_full_i[h]) begin
        w_fmt[h] = F_BRANCH_FULL;
        w_sub[h] = SF_UNDEF;
      end
      else if (tc_context_change_i[h]) w_sub[h] = SF_CONTEXT;
      else w_req[h] = 1'b0;
    end
  end

  // Nearest full slot at or after r_rr wins; a locked grant overrides the search.
  always_comb begin
    int best;
    best = NHARTS;
    w_grant = r_rr;
    for (int h = 0; h < NHARTS; h++) begin
      if (r_full[h] && ((h - int'(r_rr) + NHARTS) % NHARTS) < best) begin
        best = (h - int'(r_rr) + NHARTS) % NHARTS;
        w_grant = HW'(h);
      end
    end
    if (r_lock) w_grant = r_lock_id;
  end

  assign w_valid = |r_full;
  assign w_hs = w_valid & ready_i;

  always_comb begin
    for (int h = 0; h < NHARTS; h++) stall_o[h] = r_full[h] & ~(w_hs & (w_grant == HW'(h)));
  end

  assign w_take = w_req & ~stall_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_full <= '0;
      r_exc <= '0;
      r_rs <= '0;
      r_rr <= '0;
      r_lock <= 1'b0;
      r_lock_id <= '0;
    end else begin
      for (int h = 0; h < NHARTS; h++) begin
        if (w_take[h]) begin
          r_full[h] <= 1'b1;
          r_fmt[h] <= w_fmt[h];
          r_sub[h] <= w_sub[h];
          r_rs[h] <= w_rs[h];
          r_exc[h] <= (w_sub[h] == SF_EXCEPTION);
        end else if (w_hs && w_grant == HW'(h)) r_full[h] <= 1'b0;
      end
      if (w_hs) begin
        r_lock <= 1'b0;
        r_rr <= (w_grant == HW'(NHARTS - 1)) ? '0 : w_grant + 1'b1;
      end else if (w_valid) begin
        r_lock <= 1'b1;
        r_lock_id <= w_grant;
      end
    end
  end

`ifdef TRDB_RESYNC_EN
  localparam int CW = $clog2(RESYNC_MAX + 1);
  logic [CW-1:0] r_cnt [NHARTS];

  // Any captured SYNC restarts the interval, taking priority over counting.
  always_ff @(posedge clk_i) begin
    for (int h = 0; h < NHARTS; h++) begin
      if (!rst_ni || (w_take[h] && w_fmt[h] == F_SYNC)) r_cnt[h] <= '0;
      else if (valid_i[h] && !stall_o[h] && r_cnt[h] != CW'(RESYNC_MAX)) r_cnt[h] <= r_cnt[h] + 1'b1;
    end
  end

  always_comb begin
    for (int h = 0; h < NHARTS; h++) w_pend[h] = (r_cnt[h] == CW'(RESYNC_MAX));
  end
`else
  assign w_pend = '0;
`endif

  assign valid_o = w_valid;
  assign packet_format_o = w_valid ? r_fmt[w_grant] : F_ADDR_ONLY;
  assign packet_subformat_o = w_valid ? r_sub[w_grant] : SF_UNDEF;
  assign hart_id_o = w_valid ? w_grant : '0;
  assign resync_o = w_valid & r_rs[w_grant];
endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// tb_trdb_packet_scheduler: directed scenarios plus random traffic checked against a queue-based model.
module tb_trdb_packet_scheduler;
  import trdb_pkg::*;
  localparam int NH = 2;
  localparam int RMAX = 4;
`ifdef TRDB_RESYNC_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  typedef struct packed {
    trdb_format_t f;
    trdb_subformat_t s;
    logic rs;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ready;
  logic [NH-1:0] valid, lce, lcs, tfq, tu, tp, lud, nh, ne, np, nu, bmf, tcc, bme;
  logic [NH-1:0] stall_o;
  logic valid_o, resync_o;
  logic hart_id_o;
  trdb_format_t packet_format_o;
  trdb_subformat_t packet_subformat_o;

  int total = 0;
  int bad = 0;

  pkt_t m_q [NH][$];
  int m_cnt [NH];
  bit m_exc [NH];
  int m_rr;
  int m_lock;

  always #5 clk = ~clk;

  trdb_packet_scheduler #(.NHARTS(NH), .RESYNC_MAX(RMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_i(valid), .lc_exception_i(lce), .lc_exception_sync_i(lcs),
    .tc_first_qualified_i(tfq), .tc_unhalted_i(tu), .tc_privchange_i(tp),
    .lc_u_discontinuity_i(lud), .nc_halt_i(nh), .nc_exception_i(ne),
    .nc_privchange_i(np), .nc_unqualified_i(nu), .branch_map_full_i(bmf),
    .tc_context_change_i(tcc), .branch_map_empty_i(bme),
    .stall_o(stall_o), .valid_o(valid_o), .ready_i(ready),
    .packet_format_o(packet_format_o), .packet_subformat_o(packet_subformat_o),
    .hart_id_o(hart_id_o), .resync_o(resync_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    for (int h = 0; h < NH; h++) begin
      m_q[h].delete();
      m_cnt[h] = 0;
      m_exc[h] = 1'b0;
    end
    m_rr = 0;
    m_lock = -1;
  endfunction

  // Priority-ordered request rules for one hart; returns 1 if a packet is requested.
  function automatic bit m_decode(int h, output pkt_t p);
    p = '{f: F_SYNC, s: SF_START, rs: 1'b0};
    if (!valid[h]) return 1'b0;
    if (lce[h]) begin p.s = SF_EXCEPTION; return 1'b1; end
    if ((lcs[h] && !m_exc[h]) || tfq[h] || tu[h] || tp[h]) return 1'b1;
    if (lud[h]) begin p = '{f: bme[h] ? F_ADDR_ONLY : F_BRANCH_FULL, s: SF_UNDEF, rs: 1'b0}; return 1'b1; end
    if (RS_EN && m_cnt[h] == RMAX) begin p.rs = 1'b1; return 1'b1; end
    if (nh[h] || ne[h] || np[h] || nu[h]) begin p = '{f: bme[h] ? F_ADDR_ONLY : F_BRANCH_FULL, s: SF_UNDEF, rs: 1'b0}; return 1'b1; end
    if (bmf[h]) begin p = '{f: F_BRANCH_FULL, s: SF_UNDEF, rs: 1'b0}; return 1'b1; end
    if (tcc[h]) begin p.s = SF_CONTEXT; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic clr();
    valid = '0; lce = '0; lcs = '0; tfq = '0; tu = '0; tp = '0; lud = '0;
    nh = '0; ne = '0; np = '0; nu = '0; bmf = '0; tcc = '0; bme = '0;
  endtask

  // One clock cycle: check DUT outputs against the model, then advance both across the edge.
  task automatic cyc();
    int g;
    bit v, hs, take;
    logic [NH-1:0] st;
    pkt_t d, e;
    #1;
    v = 1'b0;
    g = 0;
    if (m_lock >= 0) begin
      g = m_lock;
      v = 1'b1;
    end else begin
      for (int k = NH - 1; k >= 0; k--) begin
        if (m_q[(m_rr + k) % NH].size() > 0) begin
          g = (m_rr + k) % NH;
          v = 1'b1;
        end
      end
    end
    hs = v && ready;
    e = v ? m_q[g][0] : '{f: F_ADDR_ONLY, s: SF_UNDEF, rs: 1'b0};
    for (int h = 0; h < NH; h++) st[h] = (m_q[h].size() > 0) && !(hs && g == h);
    total += 6;
    if (valid_o !== v) begin bad++; $display("FAIL valid_o: got %0b want %0b at %0t", valid_o, v, $time); end
    if (packet_format_o !== e.f) begin bad++; $display("FAIL format: got %0d want %0d at %0t", packet_format_o, e.f, $time); end
    if (packet_subformat_o !== e.s) begin bad++; $display("FAIL subformat: got %0d want %0d at %0t", packet_subformat_o, e.s, $time); end
    if (hart_id_o !== (v ? 1'(g) : 1'b0)) begin bad++; $display("FAIL hart_id: got %0d want %0d at %0t", hart_id_o, v ? g : 0, $time); end
    if (resync_o !== e.rs) begin bad++; $display("FAIL resync_o: got %0b want %0b at %0t", resync_o, e.rs, $time); end
    if (stall_o !== st) begin bad++; $display("FAIL stall_o: got %b want %b at %0t", stall_o, st, $time); end
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      for (int h = 0; h < NH; h++) begin
        take = m_decode(h, d) && !st[h];
        if (valid[h] && !st[h]) m_cnt[h] = (take && d.f == F_SYNC) ? 0 : (m_cnt[h] < RMAX ? m_cnt[h] + 1 : RMAX);
        if (take) m_exc[h] = (d.s == SF_EXCEPTION);
        if (hs && g == h) void'(m_q[h].pop_front());
        if (take) m_q[h].push_back(d);
      end
      if (hs) begin
        m_lock = -1;
        m_rr = (g + 1) % NH;
      end else if (v) m_lock = g;
    end
    #1;
  endtask

  task automatic do_reset();
    clr();
    ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) begin
      cyc();
      total += 4;
      if (valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid: got %0b want 0", valid_o); end
      if (stall_o !== '0) begin bad++; $display("FAIL idle_stall: got %b want 00", stall_o); end
      if (packet_format_o !== F_ADDR_ONLY) begin bad++; $display("FAIL idle_format: got %0d want %0d", packet_format_o, F_ADDR_ONLY); end
      if (packet_subformat_o !== SF_UNDEF) begin bad++; $display("FAIL idle_subformat: got %0d want %0d", packet_subformat_o, SF_UNDEF); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    valid = 2'b11; lce = 2'b01; bmf = 2'b10;
    cyc();
    clr();
    for (int c = 1; c <= 4; c++) begin
      ready = (c == 4);
      #1;
      total += 3;
      if (packet_format_o !== F_SYNC || packet_subformat_o !== SF_EXCEPTION) begin
        bad++; $display("FAIL collision_hold c%0d: got %0d/%0d want SYNC/EXCEPTION", c, packet_format_o, packet_subformat_o);
      end
      if (hart_id_o !== 1'b0) begin bad++; $display("FAIL collision_hart c%0d: got %0d want 0", c, hart_id_o); end
      if (stall_o[0] !== (c != 4)) begin bad++; $display("FAIL collision_stall0 c%0d: got %0b want %0b", c, stall_o[0], c != 4); end
      cyc();
    end
    total += 2;
    if (packet_format_o !== F_BRANCH_FULL) begin bad++; $display("FAIL collision_c5_format: got %0d want %0d", packet_format_o, F_BRANCH_FULL); end
    if (hart_id_o !== 1'b1) begin bad++; $display("FAIL collision_c5_hart: got %0d want 1", hart_id_o); end
    cyc();
  endtask

  task automatic test_exc_sync();
    do_reset();
    ready = 1'b1;
    valid = 2'b01; lce = 2'b01;
    cyc();
    lce = '0; lcs = 2'b01;
    cyc();
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL exc_sync_suppressed: got valid %0b want 0", valid_o); end
    lcs = '0; lud = 2'b01; bme = 2'b01;
    cyc();
    lud = '0; bme = '0; lcs = 2'b01;
    cyc();
    clr();
    #1;
    total += 2;
    if (valid_o !== 1'b1) begin bad++; $display("FAIL exc_sync_after_clear: got valid %0b want 1", valid_o); end
    if (packet_format_o !== F_SYNC || packet_subformat_o !== SF_START) begin
      bad++; $display("FAIL exc_sync_start: got %0d/%0d want SYNC/START", packet_format_o, packet_subformat_o);
    end
    cyc();
  endtask

  task automatic test_resync();
    do_reset();
    ready = 1'b1;
    valid = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      total += 2;
      if (valid_o !== (RS_EN && (i == 5 || i == 10))) begin bad++; $display("FAIL resync_valid i%0d: got %0b", i, valid_o); end
      if (resync_o !== (RS_EN && (i == 5 || i == 10))) begin bad++; $display("FAIL resync_flag i%0d: got %0b", i, resync_o); end
    end
    clr();
    cyc();
  endtask

  task automatic test_round_robin();
    do_reset();
    ready = 1'b1;
    valid = 2'b11; bmf = 2'b11;
    cyc();
    for (int i = 0; i < 8; i++) begin
      total += 2;
      if (valid_o !== 1'b1) begin bad++; $display("FAIL rr_valid i%0d: got %0b want 1", i, valid_o); end
      if (hart_id_o !== 1'(i % 2)) begin bad++; $display("FAIL rr_grant i%0d: got %0d want %0d", i, hart_id_o, i % 2); end
      cyc();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    valid = 2'b11; bmf = 2'b11;
    cyc();
    cyc();
    rst_n = 1'b0;
    clr();
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      total++;
      if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_reset_stale: got valid %0b want 0", valid_o); end
      ready = 1'b1;
      cyc();
    end
  endtask

  function automatic logic [NH-1:0] rare();
    return NH'($urandom & $urandom & $urandom);
  endfunction

  task automatic test_random();
    do_reset();
    repeat (600) begin
      rst_n = ($urandom_range(99) != 0);
      ready = ($urandom_range(9) < 7);
      valid = NH'($urandom | $urandom);
      lce = rare(); lcs = rare(); tfq = rare() & rare(); tu = rare() & rare(); tp = rare() & rare();
      lud = rare(); nh = rare(); ne = rare(); np = rare(); nu = rare();
      bmf = rare(); tcc = rare(); bme = NH'($urandom);
      cyc();
    end
    rst_n = 1'b1;
    clr();
    cyc();
  endtask

  initial begin
    clr();
    ready = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_collision();
    test_exc_sync();
    test_resync();
    test_round_robin();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
